// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit bus CPU: control-word layout, opcodes and
// the opcode-independent fetch words.
package cpu_pkg;

    localparam int CW_WIDTH = 16;

    localparam int CW_HLT = 15;
    localparam int CW_MI  = 14;
    localparam int CW_RI  = 13;
    localparam int CW_RO  = 12;
    localparam int CW_IO  = 11;
    localparam int CW_II  = 10;
    localparam int CW_AI  = 9;
    localparam int CW_AO  = 8;
    localparam int CW_EO  = 7;
    localparam int CW_SU  = 6;
    localparam int CW_BI  = 5;
    localparam int CW_OI  = 4;
    localparam int CW_CE  = 3;
    localparam int CW_CO  = 2;
    localparam int CW_J   = 1;
    localparam int CW_FI  = 0;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [CW_WIDTH-1:0] CW_FETCH0 = CW_WIDTH'((1 << CW_CO) | (1 << CW_MI));
    localparam logic [CW_WIDTH-1:0] CW_FETCH1 = CW_WIDTH'((1 << CW_RO) | (1 << CW_II) | (1 << CW_CE));

    function automatic logic [CW_WIDTH-1:0] cw(input int unsigned idx);
        return CW_WIDTH'(1) << idx;
    endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode table: (opcode, step, flags) -> control word.
module microcode_rom
    import cpu_pkg::*;
(
    input  logic [3:0]          i_opcode,
    input  logic [3:0]          i_step,
    input  logic                i_flag_c,
    input  logic                i_flag_z,
    output logic [CW_WIDTH-1:0] o_word
);

    always_comb begin
        o_word = '0;
        case (i_step)
            4'd0: o_word = CW_FETCH0;
            4'd1: o_word = CW_FETCH1;
            4'd2: begin
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: o_word = cw(CW_IO) | cw(CW_MI);
                    OP_LDI: o_word = cw(CW_IO) | cw(CW_AI);
                    OP_JMP: o_word = cw(CW_IO) | cw(CW_J);
                    // Untaken conditional jumps produce an empty word so they end at T2.
                    OP_JC:  o_word = i_flag_c ? (cw(CW_IO) | cw(CW_J)) : '0;
                    OP_JZ:  o_word = i_flag_z ? (cw(CW_IO) | cw(CW_J)) : '0;
                    OP_OUT: o_word = cw(CW_AO) | cw(CW_OI);
                    OP_HLT: o_word = cw(CW_HLT);
                    default: o_word = '0;
                endcase
            end
            4'd3: begin
                case (i_opcode)
                    OP_LDA:         o_word = cw(CW_RO) | cw(CW_AI);
                    OP_ADD, OP_SUB: o_word = cw(CW_RO) | cw(CW_BI);
                    OP_STA:         o_word = cw(CW_AO) | cw(CW_RI);
                    default:        o_word = '0;
                endcase
            end
            4'd4: begin
                case (i_opcode)
                    OP_ADD:  o_word = cw(CW_EO) | cw(CW_AI) | cw(CW_FI);
                    OP_SUB:  o_word = cw(CW_EO) | cw(CW_AI) | cw(CW_SU) | cw(CW_FI);
                    default: o_word = '0;
                endcase
            end
            default: o_word = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Microcode sequencer: steps T-states and decodes one control word per clock
// from the registered step, the opcode nibble and the latched ALU flags.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int   STEPS     = 5,
    parameter bit   EARLY_END = 1'b1,
    localparam int  SW        = $clog2(STEPS)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clk_en,
    input  logic [3:0]          i_opcode,
    input  logic                i_flag_c,
    input  logic                i_flag_z,
    output logic [CW_WIDTH-1:0] o_ctrl,
    output logic [SW-1:0]       o_step,
    output logic                o_halted,
    output logic                o_instr_done
);

    logic [SW-1:0]       step_q, step_d;
    logic                halted_q, halted_d;
    logic [3:0]          cur_step, nxt_step;
    logic [CW_WIDTH-1:0] cur_word, nxt_word;
    logic                is_last;

    assign cur_step = 4'(step_q);
    assign nxt_step = cur_step + 4'd1;

    microcode_rom u_rom_cur (
        .i_opcode (i_opcode),
        .i_step   (cur_step),
        .i_flag_c (i_flag_c),
        .i_flag_z (i_flag_z),
        .o_word   (cur_word)
    );

    // Lookahead word lets an instruction finish as soon as its remaining microcode is empty.
    microcode_rom u_rom_nxt (
        .i_opcode (i_opcode),
        .i_step   (nxt_step),
        .i_flag_c (i_flag_c),
        .i_flag_z (i_flag_z),
        .o_word   (nxt_word)
    );

    always_comb begin
        is_last  = (step_q == SW'(STEPS - 1)) ||
                   (EARLY_END && (cur_step >= 4'd2) && (nxt_word == '0));
        step_d   = step_q;
        halted_d = halted_q;
        if (i_clk_en && !halted_q) begin
            if (cur_word[CW_HLT]) begin
                halted_d = 1'b1;
            end else if (is_last) begin
                step_d = '0;
            end else begin
                step_d = step_q + SW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            step_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // Strobes are levels for the whole step; consumers act on the closing edge, gated by i_clk_en.
    always_comb begin
        o_ctrl = cur_word;
        if (!i_rst) begin
            o_ctrl = '0;
        end else if (halted_q) begin
            o_ctrl = cw(CW_HLT);
        end
    end

    assign o_step       = step_q;
    assign o_halted     = halted_q;
    assign o_instr_done = i_rst && !halted_q && is_last && !cur_word[CW_HLT];

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Microcode sequencer for the 8-bit bus CPU. It is the initiator side of the register load/enable interface: it steps T-states and drives the load (`*I`) and enable (`*O`) strobes that every bus register, the ALU, PC, MAR, RAM and output register consume. It decodes the instruction register's upper nibble and the ALU flags into one 16-bit control word per clock.

Parameters:
- STEPS, 5, number of microsteps per instruction (T0..T4); legal values 3..8.
- EARLY_END, 1, when 1, finish the instruction early once the remaining microcode is empty.

Ports:
- i_clk  in  1  system clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_clk_en  in  1  advance enable; when low, step state holds.
- i_opcode  in  4  IR[7:4].
- i_flag_c  in  1  latched carry flag from the flags register.
- i_flag_z  in  1  latched zero flag from the flags register.
- o_ctrl  out  16  control word: [15]HLT [14]MI [13]RI [12]RO [11]IO [10]II [9]AI [8]AO [7]EO [6]SU [5]BI [4]OI [3]CE [2]CO [1]J [0]FI.
- o_step  out  $clog2(STEPS)  current T-state.
- o_halted  out  1  sticky halt status.
- o_instr_done  out  1  high during the last step of the current instruction.

Behaviour:
- Reset (i_rst low, asynchronous):
  - step=0, halted=0.
  - o_ctrl forced to 0x0000 while reset is held; o_instr_done=0.
- After reset release: o_ctrl is decoded combinationally from the registered step, i_opcode and the flags. All consumers sample it on the next rising edge.
- Fetch steps (independent of opcode, because IR loads at the end of T1):
  - T0 = CO|MI (0x4004).
  - T1 = RO|II|CE (0x1408).
- Execute steps T2/T3/T4 by opcode (unlisted steps are 0):
  - 0 NOP: –
  - 1 LDA: IO|MI, RO|AI
  - 2 ADD: IO|MI, RO|BI, EO|AI|FI
  - 3 SUB: IO|MI, RO|BI, EO|AI|SU|FI
  - 4 STA: IO|MI, AO|RI
  - 5 LDI: IO|AI
  - 6 JMP: IO|J
  - 7 JC: IO|J only if i_flag_c, else 0
  - 8 JZ: IO|J only if i_flag_z, else 0
  - E OUT: AO|OI
  - F HLT: HLT
  - 9–D: treated as NOP
- IO places IR[3:0] on the bus; the IR zeroizes its upper nibble on output.
- Step advance on a rising edge with i_clk_en=1 and not halted:
  - Last step when step==STEPS-1, or when EARLY_END=1, step>=2 and the word for step+1 is 0.
  - The last step returns to step 0; any other step advances to step+1.
  - o_instr_done is high for exactly the last step.
  - Early-end is never evaluated at T0/T1, since the opcode is stale there.
  - NOP therefore takes 3 cycles with EARLY_END=1, and STEPS cycles with EARLY_END=0.
- Halt:
  - At a step whose word has HLT set, the edge sets halted=1 and step freezes.
  - While halted: o_ctrl=0x8000, o_instr_done=0, i_clk_en ignored.
  - Only reset clears halted.
- Flags are sampled combinationally each cycle. A JC/JZ decision follows the flag value present during T2.
- i_clk_en low: step and halted hold; o_ctrl keeps presenting the current step's word. Consumers must gate their loads with the same enable.
- Reset mid-instruction: step returns to 0 immediately. No partial microstep completes after reset assertion.

Decomposition:
- Shared package cpu_pkg:
  - CW_WIDTH=16.
  - Control bit index constants (CW_HLT..CW_FI).
  - Opcode constants (OP_NOP..OP_HLT).
  - Fetch words CW_FETCH0 / CW_FETCH1.
- Sub-module microcode_rom: purely combinational (opcode, step, flag_c, flag_z) -> 16-bit word.
  - control_sequencer instantiates it twice: once for the current step and once for the step+1 lookahead used by early-end.

Test Plan:
1. Reset: hold i_rst=0 -> o_ctrl=0x0000, o_step=0, o_halted=0. Release -> 0x4004, next edge 0x1408, o_step=1.
2. ADD (opcode 2), EARLY_END=1 -> words 0x4004, 0x1408, 0x4800, 0x1020, 0x0281. o_instr_done only at T4, then o_step=0.
3. LDA (opcode 1): EARLY_END=1 -> T3=0x1200 with o_instr_done, 4-cycle instruction. EARLY_END=0 -> 5 cycles, T4=0x0000.
4. JC (opcode 7): flag_c=1 -> T2=0x0802. flag_c=0 -> T2=0x0000 with o_instr_done=1 at T2. Same check for JZ with flag_z.
5. HLT (opcode F) -> T2=0x8000; next edge o_halted=1, o_step stays 2, o_ctrl=0x8000 for 20 cycles with i_clk_en toggling. Pulsing i_rst low recovers to step 0.
6. Hold i_clk_en=0 at T3 of SUB for 5 cycles -> o_step=3, o_ctrl=0x1020 stable. Then assert i_rst mid-cycle -> o_step=0 and o_ctrl=0x0000 without waiting for a clock edge.
